// File: rtl/inst_fetcher_pkg.sv
// Shared types and helpers for the instruction fetch stage.
//   IQ_DEPTH_DEF  : default instruction queue depth (power of two, >= 2)
//   fetch_state_t : fetch FSM encoding
//   iq_entry_t    : one queued instruction {pc, inst}
//   is_rvi()      : true when the low two bits mark a 32-bit instruction
//   align_pc()    : forces bit 0 of a redirect target to zero
package inst_fetcher_pkg;

  localparam int IQ_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_WAIT,
    FS_DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  function automatic logic is_rvi(input logic [1:0] lo);
    return lo == 2'b11;
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Icache request/response bus between the fetch stage and the icache.
//   icache_req   : one-cycle request pulse (fetcher -> cache)
//   icache_addr  : halfword-aligned fetch address (fetcher -> cache)
//   icache_valid : response valid, one or more cycles after the request
//   icache_data  : 32 bits starting at the requested address
interface inst_fetcher_if;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_valid;
  logic [31:0] icache_data;

  modport master (output icache_req, icache_addr, input icache_valid, icache_data);
  modport slave  (input icache_req, icache_addr, output icache_valid, icache_data);
endinterface

// File: rtl/inst_fetcher_queue.sv
// In-order circular FIFO of fetched instructions.
//   clk_in, rst_in : clock, async active-low reset
//   push/pop/flush : enqueue push_entry, drop head, empty the queue (flush wins)
//   head           : entry at the read pointer
//   second_pc      : pc of the entry behind the head (valid when count > 1)
//   count          : number of valid entries
// The caller never pushes when full nor pops when empty.
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  iq_entry_t                push_entry,
  output iq_entry_t                head,
  output logic [31:0]              second_pc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int IQ_BIT = $clog2(DEPTH);
  localparam int CW     = IQ_BIT + 1;

  iq_entry_t          mem [DEPTH];
  logic [IQ_BIT-1:0]  rd_ptr;
  logic [IQ_BIT-1:0]  wr_ptr;
  logic [IQ_BIT-1:0]  rd_next;

  assign rd_next   = rd_ptr + 1'b1;
  assign head      = mem[rd_ptr];
  assign second_pc = mem[rd_next].pc;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_next;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clk_in) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/inst_fetcher.sv
// Sequential instruction fetch stage feeding the RVC decoder.
//   clk_in, rst_in     : clock, async active-low reset
//   rdy_in             : global ready; low freezes state (responses go to a skid)
//   wrong_predicted    : ROB flush, redirect to correct_pc
//   issue_signal       : decoder consumed the head; next_pc is its predicted successor
//   jalr_stall         : decoder hold (head is held regardless)
//   start_decode, inst, inst_addr : head of the instruction queue
//   icache             : request/response bus (master side)
//
// state      | meaning
// FS_IDLE    | no request outstanding
// FS_WAIT    | request outstanding, response will be queued
// FS_DISCARD | request outstanding, response is stale and will be dropped
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int          IQ_DEPTH = IQ_DEPTH_DEF,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           wrong_predicted,
  input  logic [31:0]    correct_pc,
  input  logic           issue_signal,
  input  logic [31:0]    next_pc,
  input  logic           jalr_stall,
  output logic           start_decode,
  output logic [31:0]    inst,
  output logic [31:0]    inst_addr,
  inst_fetcher_if.master icache
);
  localparam int CW = $clog2(IQ_DEPTH) + 1;

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic         hold_valid;
  logic [31:0]  hold_data;
  logic         req_q;
  logic [31:0]  addr_q;

  iq_entry_t    head;
  iq_entry_t    push_entry;
  logic [31:0]  second_pc;
  logic [CW-1:0] count;

  logic         resp, pop, mispredict, redirect, push, can_req;
  logic [31:0]  resp_data, expect_pc, next_al, correct_al, redirect_pc;
  logic         unused_ok;

  // The decoder already holds the head by not issuing; the stall flag adds nothing here.
  assign unused_ok = jalr_stall;

  assign next_al    = align_pc(next_pc);
  assign correct_al = align_pc(correct_pc);

  always_comb begin
    resp_data   = hold_valid ? hold_data : icache.icache_data;
    resp        = rdy_in && (state != FS_IDLE) && (hold_valid || icache.icache_valid);
    pop         = rdy_in && !wrong_predicted && issue_signal && (count != '0);
    // Successor of the popped head: the next queued pc, or where fetch will continue.
    expect_pc   = (count > CW'(1)) ? second_pc : fetch_pc;
    mispredict  = pop && (next_al != expect_pc);
    redirect    = rdy_in && (wrong_predicted || mispredict);
    redirect_pc = wrong_predicted ? correct_al : next_al;
    push        = resp && !redirect && (state == FS_WAIT);
    // A request reserves the slot its response will fill.
    can_req     = rdy_in && !redirect && (state == FS_IDLE) && (count < CW'(IQ_DEPTH));
    push_entry.pc   = fetch_pc;
    push_entry.inst = is_rvi(resp_data[1:0]) ? resp_data : {16'h0, resp_data[15:0]};
  end

  inst_queue #(.DEPTH(IQ_DEPTH)) u_queue (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .push_entry (push_entry),
    .head       (head),
    .second_pc  (second_pc),
    .count      (count)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= FS_IDLE;
      fetch_pc   <= RESET_PC;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      req_q <= 1'b0;
      if (!rdy_in) begin
        if (icache.icache_valid && state != FS_IDLE) begin
          hold_valid <= 1'b1;
          hold_data  <= icache.icache_data;
        end
      end else begin
        hold_valid <= 1'b0;
        if (redirect) begin
          fetch_pc <= redirect_pc;
          state    <= (state != FS_IDLE && !resp) ? FS_DISCARD : FS_IDLE;
        end else if (resp) begin
          state <= FS_IDLE;
          if (state == FS_WAIT)
            fetch_pc <= fetch_pc + (is_rvi(resp_data[1:0]) ? 32'd4 : 32'd2);
        end else if (can_req) begin
          req_q  <= 1'b1;
          addr_q <= fetch_pc;
          state  <= FS_WAIT;
        end
      end
    end
  end

  assign icache.icache_req  = req_q;
  assign icache.icache_addr = addr_q;

  assign start_decode = (count != '0);
  assign inst         = head.inst;
  assign inst_addr    = head.pc;

endmodule

// File: tb/tb_inst_fetcher.sv
module tb_inst_fetcher;
  import inst_fetcher_pkg::*;

  localparam int DEPTH = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic        wrong_predicted = 1'b0;
  logic [31:0] correct_pc = '0;
  logic        issue_signal = 1'b0;
  logic [31:0] next_pc = '0;
  logic        jalr_stall = 1'b0;
  logic        start_decode;
  logic [31:0] inst;
  logic [31:0] inst_addr;

  inst_fetcher_if icache();

  inst_fetcher #(.IQ_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .wrong_predicted (wrong_predicted),
    .correct_pc      (correct_pc),
    .issue_signal    (issue_signal),
    .next_pc         (next_pc),
    .jalr_stall      (jalr_stall),
    .start_decode    (start_decode),
    .inst            (inst),
    .inst_addr       (inst_addr),
    .icache          (icache)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc, m_addr, m_hdata;
  bit          m_out, m_disc, m_hold, m_req;

  // icache contents and responder
  logic [15:0] hw [256];
  bit          c_pend;
  int          c_cnt;
  int          c_maxd;
  logic [31:0] c_addr;

  int rdy_pct, wp_pct, iss_pct, mis_pct, jflip_pct;

  function automatic logic [31:0] cache_word(input logic [31:0] a);
    logic [7:0] i0, i1;
    i0 = a[8:1];
    i1 = i0 + 8'd1;
    return {hw[i1], hw[i0]};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_fpc = 32'h0; m_addr = 32'h0; m_hdata = 32'h0;
    m_out = 0; m_disc = 0; m_hold = 0; m_req = 0;
  endtask

  task automatic model_step();
    bit          resp, redir;
    logic [31:0] d, succ, fpc0;
    int          n0, len;
    bit          out0;
    ent_t        e;
    n0 = mq.size(); out0 = m_out; fpc0 = m_fpc;
    m_req = 0;
    if (!rdy_in) begin
      if (icache.icache_valid && m_out) begin
        m_hold = 1; m_hdata = icache.icache_data;
      end
      return;
    end
    resp = m_out && (icache.icache_valid || m_hold);
    d = m_hold ? m_hdata : icache.icache_data;
    m_hold = 0;
    redir = 0;
    if (wrong_predicted) begin
      redir = 1; m_fpc = {correct_pc[31:1], 1'b0};
    end else if (issue_signal && n0 > 0) begin
      succ = (n0 > 1) ? mq[1].pc : m_fpc;
      void'(mq.pop_front());
      if ({next_pc[31:1], 1'b0} != succ) begin
        redir = 1; m_fpc = {next_pc[31:1], 1'b0};
      end
    end
    if (redir) begin
      mq.delete();
      m_disc = m_out && !resp;
      if (resp) m_out = 0;
    end else if (resp) begin
      m_out = 0;
      if (m_disc) m_disc = 0;
      else begin
        len = (d[1:0] == 2'b11) ? 4 : 2;
        e.pc = m_fpc;
        e.ins = (len == 4) ? d : {16'h0, d[15:0]};
        mq.push_back(e);
        m_fpc = m_fpc + 32'(len);
      end
    end
    if (!redir && !out0 && n0 < DEPTH) begin
      m_req = 1; m_addr = fpc0; m_out = 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_outputs();
    chk1("start_decode", start_decode, mq.size() != 0);
    chk1("icache_req", icache.icache_req, m_req);
    chk32("icache_addr", icache.icache_addr, m_addr);
    if (mq.size() != 0) begin
      chk32("inst", inst, mq[0].ins);
      chk32("inst_addr", inst_addr, mq[0].pc);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic drive();
    logic [31:0] succ;
    rdy_in = ($urandom_range(99) < rdy_pct);
    wrong_predicted = ($urandom_range(99) < wp_pct);
    correct_pc = (32'($urandom_range(255)) << 1) | 32'($urandom_range(1));
    if ($urandom_range(99) < jflip_pct) jalr_stall = !jalr_stall;
    issue_signal = !jalr_stall && ($urandom_range(99) < iss_pct);
    succ = (mq.size() > 1) ? mq[1].pc : m_fpc;
    if ($urandom_range(99) < mis_pct)
      next_pc = (32'($urandom_range(255)) << 1) | 32'($urandom_range(1));
    else
      next_pc = succ | 32'($urandom_range(1));
    icache.icache_valid = 1'b0;
    icache.icache_data = $urandom;
    if (c_pend) begin
      c_cnt--;
      if (c_cnt <= 0) begin
        icache.icache_valid = 1'b1;
        icache.icache_data = cache_word(c_addr);
        c_pend = 0;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_in);
    #1;
    cmp_outputs();
    if (icache.icache_req) begin
      c_pend = 1;
      c_cnt = $urandom_range(c_maxd, 1);
      c_addr = icache.icache_addr;
    end
  endtask

  initial begin
    bit ok;
    int n;
    for (int i = 0; i < 256; i++) begin
      hw[i] = 16'($urandom);
      if ($urandom_range(1) == 1) hw[i][1:0] = 2'b11;
      else if (hw[i][1:0] == 2'b11) hw[i][0] = 1'b0;
    end
    hw[0] = 16'h0013; hw[1] = 16'h0000; hw[2] = 16'h4501; hw[3] = 16'h0001;
    hw[4] = 16'hA001; hw[5] = 16'h0001; hw[6] = 16'h0001; hw[7] = 16'h0001;
    c_pend = 0; c_cnt = 0; c_addr = 0; c_maxd = 3;
    rdy_pct = 100; wp_pct = 0; iss_pct = 0; mis_pct = 0; jflip_pct = 0;
    icache.icache_valid = 1'b0;
    icache.icache_data = 32'h0;
    model_reset();

    #12;
    chk1("rst_start_decode", start_decode, 1'b0);
    chk1("rst_req", icache.icache_req, 1'b0);
    chk32("rst_addr", icache.icache_addr, 32'h0);
    #10 rst_in = 1'b1;

    // T1: 32-bit then RVC, next request at 6
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      drive(); cycle();
      if (mq.size() == 2) begin ok = 1; break; end
    end
    chk1("t1_fill", ok, 1'b1);
    if (ok) begin
      chk32("t1_q0_pc", mq[0].pc, 32'h0);
      chk32("t1_q0_inst", mq[0].ins, 32'h13);
      chk32("t1_q1_pc", mq[1].pc, 32'h4);
      chk32("t1_q1_inst", mq[1].ins, 32'h4501);
      chk32("t1_head_inst", inst, 32'h13);
    end
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      drive(); cycle();
      if (icache.icache_req) begin ok = 1; break; end
    end
    chk1("t1_req_seen", ok, 1'b1);
    chk32("t1_next_addr", icache.icache_addr, 32'h6);

    // T2: mispredicted follow-on from head 8 with a request in flight
    iss_pct = 100;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      drive();
      if (mq.size() > 0 && mq[0].pc == 32'h8) issue_signal = 1'b0;
      cycle();
      if (mq.size() >= 2 && mq[0].pc == 32'h8 && m_out) begin ok = 1; break; end
    end
    chk1("t2_setup", ok, 1'b1);
    iss_pct = 0;
    drive();
    issue_signal = 1'b1; next_pc = 32'h40; wrong_predicted = 1'b0;
    cycle();
    chk1("t2_flushed", start_decode, 1'b0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      drive(); cycle();
      if (icache.icache_req) begin ok = 1; break; end
    end
    chk1("t2_req_seen", ok, 1'b1);
    chk32("t2_req_addr", icache.icache_addr, 32'h40);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      drive(); cycle();
      if (start_decode) begin ok = 1; break; end
    end
    chk1("t2_head_seen", ok, 1'b1);
    chk32("t2_head_pc", inst_addr, 32'h40);

    // T3: wrong_predicted coincident with response and issue
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      drive();
      if (icache.icache_valid && mq.size() > 0) begin
        wrong_predicted = 1'b1; correct_pc = 32'h100; issue_signal = 1'b1;
        ok = 1;
      end
      cycle();
      if (ok) break;
    end
    chk1("t3_hit", ok, 1'b1);
    chk1("t3_empty", start_decode, 1'b0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      drive(); cycle();
      if (icache.icache_req) begin ok = 1; break; end
    end
    chk1("t3_req_seen", ok, 1'b1);
    chk32("t3_req_addr", icache.icache_addr, 32'h100);

    // T4: fill under jalr_stall, then one issue frees exactly one slot
    jalr_stall = 1'b1;
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      drive(); cycle();
      if (mq.size() == DEPTH && !m_out) begin ok = 1; break; end
    end
    chk1("t4_full", ok, 1'b1);
    chk32("t4_head_pc", inst_addr, 32'h100);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      drive(); cycle();
      if (icache.icache_req) n++;
    end
    chk32("t4_no_req_full", 32'(n), 32'd0);
    drive();
    jalr_stall = 1'b0; issue_signal = 1'b1;
    cycle();
    jalr_stall = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      drive(); cycle();
      if (icache.icache_req) n++;
    end
    chk32("t4_one_req", 32'(n), 32'd1);

    // T5: async reset while a request is outstanding
    jalr_stall = 1'b0; iss_pct = 100;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      drive(); cycle();
      if (icache.icache_req) begin ok = 1; break; end
    end
    chk1("t5_setup", ok, 1'b1);
    iss_pct = 0;
    c_pend = 1; c_cnt = 4;
    rdy_in = 1'b0; wrong_predicted = 1'b0; issue_signal = 1'b0;
    icache.icache_valid = 1'b0;
    #2 rst_in = 1'b0;
    #1;
    chk1("t5_rst_start_decode", start_decode, 1'b0);
    chk1("t5_rst_req", icache.icache_req, 1'b0);
    chk32("t5_rst_addr", icache.icache_addr, 32'h0);
    model_reset();
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    rdy_pct = 0;
    for (int i = 0; i < 6; i++) begin
      drive(); cycle();
    end
    chk1("t5_late_ignored", start_decode, 1'b0);
    rdy_pct = 100;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      drive(); cycle();
      if (start_decode) begin ok = 1; break; end
    end
    chk1("t5_refetch", ok, 1'b1);
    chk32("t5_head_pc", inst_addr, 32'h0);
    chk32("t5_head_inst", inst, 32'h13);

    // Random phase
    rdy_pct = 85; wp_pct = 3; iss_pct = 50; mis_pct = 10; jflip_pct = 10; c_maxd = 4;
    for (int i = 0; i < 3000; i++) begin
      drive(); cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
